// File: rtl/ergene_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ergene_pkg
//  Description : Shared defaults, dump sequencer state type and the
//                lowest-set-bit index helper.
//  Revision    : 1.0
// ============================================================================
package ergene_pkg;

    localparam int N_CH  = 16;
    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_SETTLE  = 3'd2,
        S_PRESENT = 3'd3,
        S_GAP     = 3'd4,
        S_DONE    = 3'd5
    } dump_seq_state_t;

    // Scans from the top so the lowest set bit is the last one written.
    function automatic logic [IDX_W-1:0] onehot_lsb_idx(input logic [N_CH-1:0] sel);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (sel[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dump_sequencer_onehot_to_idx.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_to_idx
//  Description : Combinational lowest-set-bit encoder with an any-bit flag.
//  Revision    : 1.0
// ============================================================================
module onehot_to_idx #(
    parameter int N_CH  = ergene_pkg::N_CH,
    parameter int IDX_W = ergene_pkg::IDX_W
) (
    input  logic [N_CH-1:0]  i_sel,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    assign o_any = |i_sel;

    // The shared helper is fixed to the package widths; other widths use a local scan.
    if (N_CH == ergene_pkg::N_CH && IDX_W == ergene_pkg::IDX_W) begin : g_pkg_fn
        assign o_idx = ergene_pkg::onehot_lsb_idx(i_sel);
    end else begin : g_generic
        always_comb begin
            o_idx = '0;
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (i_sel[i]) o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dump_sequencer
//  Description : Arms the priority FSM with a latched event mask and walks
//                the selected channels over a valid/ready index handshake.
//  Revision    : 1.0
// ============================================================================
module dump_sequencer #(
    parameter int N_CH       = ergene_pkg::N_CH,
    parameter int IDX_W      = ergene_pkg::IDX_W,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             trig_i,
    input  logic [N_CH-1:0]  event_mask_i,
    input  logic [N_CH-1:0]  ch_sel_i,
    input  logic             last_i,
    input  logic             tx_ready_i,
    output logic             arm_o,
    output logic [N_CH-1:0]  mask_o,
    output logic             dump_o,
    output logic             ch_valid_o,
    output logic [IDX_W-1:0] ch_idx_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             empty_frame_o,
    output logic             drop_o,
    output logic             sel_err_o
);
    import ergene_pkg::*;

    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    dump_seq_state_t    r_state, w_state_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic               r_arm, w_arm_nxt;
    logic [N_CH-1:0]    r_mask, w_mask_nxt;
    logic               r_dump, w_dump_nxt;
    logic               r_valid, w_valid_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_empty, w_empty_nxt;
    logic               r_drop, w_drop_nxt;
    logic               r_sel_err, w_sel_err_nxt;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_sel_any;

    onehot_to_idx #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_onehot_to_idx (
        .i_sel (ch_sel_i),
        .o_idx (w_sel_idx),
        .o_any (w_sel_any)
    );

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
            r_arm     <= 1'b0;
            r_mask    <= '0;
            r_dump    <= 1'b0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_empty   <= 1'b0;
            r_drop    <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_arm     <= w_arm_nxt;
            r_mask    <= w_mask_nxt;
            r_dump    <= w_dump_nxt;
            r_valid   <= w_valid_nxt;
            r_idx     <= w_idx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_empty   <= w_empty_nxt;
            r_drop    <= w_drop_nxt;
            r_sel_err <= w_sel_err_nxt;
        end
    end

    // Next-state logic also computes every output one cycle early so all outputs are registered.
    always_comb begin
        w_state_nxt   = r_state;
        w_gap_cnt_nxt = r_gap_cnt;
        w_arm_nxt     = 1'b0;
        w_mask_nxt    = '0;
        w_dump_nxt    = 1'b0;
        w_valid_nxt   = r_valid;
        w_idx_nxt     = r_idx;
        w_done_nxt    = 1'b0;
        w_empty_nxt   = 1'b0;
        w_drop_nxt    = trig_i && (r_state != S_IDLE);
        w_sel_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (trig_i) begin
                    if (|event_mask_i) begin
                        w_state_nxt = S_ARM;
                        w_arm_nxt   = 1'b1;
                        w_mask_nxt  = event_mask_i;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_empty_nxt = 1'b1;
                    end
                end
            end
            S_ARM: begin
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_sel_any) begin
                    w_state_nxt = S_PRESENT;
                    w_valid_nxt = 1'b1;
                    w_idx_nxt   = w_sel_idx;
                end else begin
                    w_state_nxt   = S_IDLE;
                    w_sel_err_nxt = 1'b1;
                end
            end
            S_PRESENT: begin
                if (r_valid && tx_ready_i) begin
                    w_valid_nxt   = 1'b0;
                    w_dump_nxt    = 1'b1;
                    w_gap_cnt_nxt = c_GAP_W'(GAP_CYCLES);
                    w_state_nxt   = last_i ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                // The dump cycle itself is spent here, so the count starts at GAP_CYCLES.
                if (r_gap_cnt == '0) begin
                    if (w_sel_any) begin
                        w_state_nxt = S_PRESENT;
                        w_valid_nxt = 1'b1;
                        w_idx_nxt   = w_sel_idx;
                    end else begin
                        w_state_nxt   = S_IDLE;
                        w_sel_err_nxt = 1'b1;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - c_GAP_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign arm_o         = r_arm;
    assign mask_o        = r_mask;
    assign dump_o        = r_dump;
    assign ch_valid_o    = r_valid;
    assign ch_idx_o      = r_idx;
    assign busy_o        = r_busy;
    assign frame_done_o  = r_done;
    assign empty_frame_o = r_empty;
    assign drop_o        = r_drop;
    assign sel_err_o     = r_sel_err;

endmodule
`default_nettype wire
